apb_mem_slave: RTL
==================

// Module: apb_mem_slave
// PURPOSE
// - Parametrised single-port memory slave on the valid/ready bus (addr, wdata, rdata, wr_rd, valid, ready).
// - Successor of the fixed-width memory: width, depth and wait states are configurable; out-of-range access handling is added.
// - Sits behind the bus interface as the DUT; bfm drives valid/wr_rd/addr/wdata, monitor samples all signals.
// PARAMETERS
// - WIDTH        32  data width in bits (rdata/wdata)
// - ADDR_WIDTH   8   word-address width
// - DEPTH        256 number of implemented words; DEPTH <= 2**ADDR_WIDTH
// - WAIT_CYCLES  0   extra wait states inserted before ready (0..15)
// PORTS
// - clk     in   1           clock, all logic on posedge
// - rst     in   1           reset, asynchronous, active-high
// - addr    in   ADDR_WIDTH  word address, held stable by master while valid && !ready
// - wdata   in   WIDTH       write data, held stable with addr
// - wr_rd   in   1           1 = write, 0 = read
// - valid   in   1           master request
// - ready   out  1           one-cycle completion pulse, registered
// - rdata   out  WIDTH       read data, valid in the ready cycle of a read, registered
// - slverr  out  1           error flag with ready (only when APB_MEM_ERR_EN defined)
// BEHAVIOUR
// - Reset (async, active-high): ready=0, rdata=0, slverr=0, state=IDLE, wait counter=0.
// - Memory array is not reset; contents undefined until written.
// - FSM states: IDLE, WAIT, RESP.
//   - IDLE: valid sampled 1 -> latch addr/wdata/wr_rd; WAIT_CYCLES==0 -> RESP, else WAIT with cnt=WAIT_CYCLES-1.
//   - WAIT: cnt==0 -> RESP, else cnt--.
//   - RESP: ready=1 for exactly one cycle, then IDLE unconditionally.
// - Latency: ready high in the cycle after the (WAIT_CYCLES+1)th posedge following the edge that sampled valid in IDLE.
//   WAIT_CYCLES=0 -> ready one cycle after valid sampled.
// - Write: mem[addr] <= wdata on the edge entering RESP; rdata unchanged on writes.
// - Read: rdata <= mem[addr] on the edge entering RESP; rdata holds last read value afterwards.
// - Read-after-write same address, back-to-back: read returns the newly written data.
// - Master drops valid in the ready cycle; valid still 1 on the edge after ready -> new transfer (back-to-back allowed).
// - valid dropped during WAIT: transfer still completes (request already latched); no abort.
// - Address range: addr >= DEPTH -> write discarded, read returns 0; ready timing unchanged.
// - Addresses in range wrap never; no address increment/burst.
// - Reset asserted mid-transfer: transfer aborted, no memory write, outputs to reset values immediately.
// CONFIGURATION
// - APB_MEM_ERR_EN defined: slverr port present; slverr=1 in the ready cycle of an out-of-range access, else 0.
// - APB_MEM_ERR_EN undefined: no slverr port; out-of-range accesses complete silently as above.
// TESTING
// - Reset: rst=1 mid-WAIT with wr_rd=1 -> ready=0, rdata=0, subsequent read of that addr does not return the aborted data.
// - WAIT_CYCLES=0: write addr 0x05 data 0xDEADBEEF, then read 0x05 -> ready 1 cycle after valid each, rdata=0xDEADBEEF.
// - WAIT_CYCLES=3: read addr 0x10 -> ready exactly 4 cycles after valid sampled, single-cycle pulse.
// - Back-to-back: valid held high across write 0x20=0x1234 then read 0x20 -> second ready returns 0x1234.
// - DEPTH=128, APB_MEM_ERR_EN: write addr 0x90 -> ready with slverr=1; read 0x90 -> rdata=0, slverr=1; 0x7F access -> slverr=0.
// - Full sweep: write addr=i data=~i for all i<DEPTH, read back all -> every rdata matches, no slverr.

Source files
------------

// File: rtl/apb_mem_slave.sv
// -----------------------------------------------------------------------------
// apb_mem_slave
//
// Single-port word memory behind a valid/ready request bus. Width, depth and
// the number of wait states before the response are parameters. An access to
// a word address at or beyond DEPTH completes with normal timing, but a write
// is dropped and a read returns zero.
//
// Optional feature (compile-time macro):
//   APB_MEM_ERR_EN  adds the slverr output. slverr is 1 in the ready cycle of
//                   an out-of-range access and 0 otherwise. Without the macro
//                   the port does not exist.
//
// Parameters:
//   WIDTH        data width in bits
//   ADDR_WIDTH   word-address width
//   DEPTH        number of implemented words (DEPTH <= 2**ADDR_WIDTH)
//   WAIT_CYCLES  extra wait states before ready (0..15)
//
// Ports:
//   clk        in   clock; all logic on posedge
//   rst        in   asynchronous active-high reset
//   addr       in   word address; the master holds it while valid && !ready
//   wdata      in   write data; held together with addr
//   wr_rd      in   1 = write, 0 = read
//   valid      in   master request
//   ready      out  registered one-cycle completion pulse
//   rdata      out  registered read data; valid in the ready cycle of a read,
//                   and holds the last read value afterwards
//   slverr     out  out-of-range flag with ready (APB_MEM_ERR_EN only)
//   fsm_state  out  current FSM state for observation (0 IDLE, 1 WAIT, 2 RESP)
//
// Handshake: the request is captured on the first posedge on which the FSM is
// IDLE and valid is 1. Exactly one ready pulse answers it. The pulse appears
// (WAIT_CYCLES+1) cycles after that capturing edge. The master drops valid in
// the ready cycle. If valid is still 1 on the next edge, that edge starts a
// new transfer. Dropping valid before ready does not cancel a captured
// request.
// -----------------------------------------------------------------------------
module apb_mem_slave #(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  wr_rd,
  input  logic                  valid,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata,
`ifdef APB_MEM_ERR_EN
  output logic                  slverr,
`endif
  output logic [1:0]            fsm_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    latch;   // capture the request this edge
  logic                    access;  // memory access on this edge (entering RESP)

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WIDTH-1:0]        wdata_q;
  logic                    wr_q;

  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [WIDTH-1:0]        cur_wdata;
  logic                    cur_wr;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;

  logic [WIDTH-1:0]        mem [DEPTH];

  assign fsm_state = state;

  // When WAIT_CYCLES is 0, RESP is entered on the capturing edge itself.
  // The latched copy does not exist yet at that edge, so in IDLE the access
  // uses the live bus.
  assign cur_addr  = (state == IDLE) ? addr  : addr_q;
  assign cur_wdata = (state == IDLE) ? wdata : wdata_q;
  assign cur_wr    = (state == IDLE) ? wr_rd : wr_q;
  assign in_range  = 32'(cur_addr) < DEPTH;
  assign idx       = cur_addr[IDX_W-1:0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            access    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          access    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ready   <= 1'b0;
      rdata   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // The pulse follows the RESP cycle. During the pulse the FSM is already
      // IDLE, so the edge that ends the pulse can start the next transfer.
      ready <= (state == RESP);
      if (latch) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        wr_q    <= wr_rd;
      end
      if (access && !cur_wr) begin
        rdata <= in_range ? mem[idx] : '0;
      end
    end
  end

`ifdef APB_MEM_ERR_EN
  logic oor_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oor_q  <= 1'b0;
      slverr <= 1'b0;
    end else begin
      if (access) begin
        oor_q <= !in_range;
      end
      slverr <= (state == RESP) && oor_q;
    end
  end
`endif

  // Storage is not reset. Gating the write with rst keeps a request that
  // is live while reset is asserted out of the array.
  always_ff @(posedge clk) begin
    if (access && cur_wr && in_range && !rst) begin
      mem[idx] <= cur_wdata;
    end
  end

endmodule
